ristretto_if_fetch_unit: RTL

//  Instruction fetch stage; sits directly upstream of the IF->DEC pipeline register.

---
 rtl/ristretto_if_stage_pkg.sv | 23 ++
 rtl/ristretto_if_prefetch_fifo.sv | 56 +++++
 rtl/ristretto_if_fetch_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ristretto_if_stage_pkg.sv
// ristretto_if_stage_pkg
//   Shared constants and types for the instruction fetch stage:
//   NOP encoding, BRANCH opcode, fetch FSM states and penalty codes.
package ristretto_if_stage_pkg;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      ABORT
   } fetch_state_t;

   localparam logic [1:0] PEN_NONE     = 2'b00;
   localparam logic [1:0] PEN_REDIRECT = 2'b01;

   function automatic logic is_branch(input logic [6:0] opcode);
      return opcode == OPC_BRANCH;
   endfunction

endpackage

// File: rtl/ristretto_if_prefetch_fifo.sv
// ristretto_if_prefetch_fifo
//   Synchronous FIFO buffering fetched {instruction, pc} pairs.
//   Ports:
//     clk_i, rst_i   clock, synchronous active-high reset
//     flush_i        drop all entries (wins over push/pop)
//     push_i/wdata_i write one entry
//     pop_i/rdata_o  read head (rdata_o shows head combinationally)
//     count_o        number of valid entries
//     full_o/empty_o occupancy flags
module ristretto_if_prefetch_fifo #(
   parameter int Width = 64,
   parameter int Depth = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [Width-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [Width-1:0]           rdata_o,
   output logic [$clog2(Depth+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/ristretto_if_fetch_unit.sv
// ristretto_if_fetch_unit
//   Instruction fetch stage feeding the IF->DEC register. Issues word
//   requests on a req/gnt/rvalid bus, buffers responses in a prefetch FIFO
//   and hands one instruction per cycle to decode. Redirects flush the FIFO
//   and discard every response still in flight.
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     instr_req_o/addr_o/gnt_i     request channel (held until granted)
//     instr_rvalid_i/rdata_i       in-order response channel
//     redirect_i/redirect_pc_i     branch/jump/trap redirect
//     fetch_stall_i                hold delivery toward decode
//     fetch_instr_o                delivered instruction
//     fetch_new_instr_o            one-cycle pulse per delivery
//     fetch_pb_instr_tag_o         delivered instruction is a BRANCH
//     fetch_penality_o             PEN_REDIRECT on first instr after redirect
//     fetch_next_pc_o              delivered instruction address + 4
module ristretto_if_fetch_unit
   import ristretto_if_stage_pkg::*;
#(
   parameter int                   DataWidth      = 32,
   parameter logic [DataWidth-1:0] BootAddr       = '0,
   parameter int                   FifoDepth      = 2,
   parameter int                   MaxOutstanding = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic                 instr_req_o,
   output logic [DataWidth-1:0] instr_addr_o,
   input  logic                 instr_gnt_i,
   input  logic                 instr_rvalid_i,
   input  logic [DataWidth-1:0] instr_rdata_i,
   input  logic                 redirect_i,
   input  logic [DataWidth-1:0] redirect_pc_i,
   input  logic                 fetch_stall_i,
   output logic [DataWidth-1:0] fetch_instr_o,
   output logic                 fetch_new_instr_o,
   output logic                 fetch_pb_instr_tag_o,
   output logic [1:0]           fetch_penality_o,
   output logic [DataWidth-1:0] fetch_next_pc_o
);

   localparam int                   CntW   = $clog2(FifoDepth + 1);
   localparam int                   OsW    = $clog2(MaxOutstanding + 1);
   localparam logic [DataWidth-1:0] PcStep = DataWidth'(4);

   fetch_state_t         state_q, state_d;
   logic [DataWidth-1:0] fetch_pc_q, fetch_pc_d;
   logic [DataWidth-1:0] target_q, target_d;
   logic [DataWidth-1:0] rsp_pc_q, rsp_pc_d;
   logic [OsW-1:0]       outstanding_q, outstanding_d;
   logic [OsW-1:0]       discard_q, discard_d;
   logic                 pen_pending_q;

   logic [DataWidth-1:0] instr_q, next_pc_q;
   logic                 new_q, tag_q;
   logic [1:0]           pen_q;

   logic                   req, granted, load_pc, rsp, drop_rsp, issue_ok;
   logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CntW-1:0]        fifo_count;
   logic [2*DataWidth-1:0] fifo_wdata, fifo_rdata;
   logic [DataWidth-1:0]   redirect_target;

   assign redirect_target = redirect_pc_i & ~DataWidth'(3);

   assign rsp       = instr_rvalid_i;
   assign drop_rsp  = redirect_i || (discard_q != '0);
   assign fifo_push = rsp && !drop_rsp;
   assign fifo_pop  = !fetch_stall_i && !fifo_empty && !redirect_i;

   // Each outstanding request owns a FIFO slot; a slot being popped this
   // cycle is already free for the next response, which keeps 1 instr/cycle.
   assign issue_ok = (int'(outstanding_q) + int'(fifo_count) - int'(fifo_pop) < FifoDepth)
                  && (int'(outstanding_q) < MaxOutstanding);

   // Responses return in order, so the pc of the next kept response is
   // tracked from the last fetch-pc reload.
   assign fifo_wdata = {instr_rdata_i, rsp_pc_q};

   ristretto_if_prefetch_fifo #(
      .Width (2 * DataWidth),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (redirect_i),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      target_d   = target_q;
      req        = 1'b0;
      load_pc    = 1'b0;
      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (redirect_i) begin
               fetch_pc_d = redirect_target;
               load_pc    = 1'b1;
            end
         end
         FETCH: begin
            // No request is pending here, so a redirect can suppress issue.
            if (redirect_i) begin
               fetch_pc_d = redirect_target;
               load_pc    = 1'b1;
            end else if (issue_ok) begin
               req = 1'b1;
               if (instr_gnt_i) fetch_pc_d = fetch_pc_q + PcStep;
               else             state_d    = HOLD;
            end
         end
         HOLD: begin
            req = 1'b1;
            if (instr_gnt_i) begin
               state_d = FETCH;
               if (redirect_i) begin
                  fetch_pc_d = redirect_target;
                  load_pc    = 1'b1;
               end else begin
                  fetch_pc_d = fetch_pc_q + PcStep;
               end
            end else if (redirect_i) begin
               target_d = redirect_target;
               state_d  = ABORT;
            end
         end
         ABORT: begin
            // Old request stays on the bus; a newer redirect replaces the target.
            req = 1'b1;
            if (instr_gnt_i) begin
               state_d    = FETCH;
               fetch_pc_d = redirect_i ? redirect_target : target_q;
               load_pc    = 1'b1;
            end else if (redirect_i) begin
               target_d = redirect_target;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign granted = req && instr_gnt_i;

   always_comb begin
      outstanding_d = outstanding_q + OsW'(granted) - OsW'(rsp);
      // A redirect condemns everything still in flight, including a request
      // granted in the same cycle from HOLD/ABORT.
      if (redirect_i) begin
         discard_d = outstanding_d;
      end else begin
         discard_d = discard_q + OsW'(granted && (state_q == ABORT))
                               - OsW'(rsp && (discard_q != '0));
      end
      if (load_pc)        rsp_pc_d = fetch_pc_d;
      else if (fifo_push) rsp_pc_d = rsp_pc_q + PcStep;
      else                rsp_pc_d = rsp_pc_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         fetch_pc_q    <= BootAddr;
         target_q      <= BootAddr;
         rsp_pc_q      <= BootAddr;
         outstanding_q <= '0;
         discard_q     <= '0;
         pen_pending_q <= 1'b0;
         new_q         <= 1'b0;
         instr_q       <= DataWidth'(NOP_INSTR);
         tag_q         <= 1'b0;
         pen_q         <= PEN_NONE;
         next_pc_q     <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         target_q      <= target_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         new_q         <= fifo_pop;
         if (redirect_i)    pen_pending_q <= 1'b1;
         else if (fifo_pop) pen_pending_q <= 1'b0;
         if (fifo_pop) begin
            instr_q   <= fifo_rdata[2*DataWidth-1:DataWidth];
            tag_q     <= is_branch(fifo_rdata[DataWidth+6:DataWidth]);
            pen_q     <= pen_pending_q ? PEN_REDIRECT : PEN_NONE;
            next_pc_q <= fifo_rdata[DataWidth-1:0] + PcStep;
         end
      end
   end

   // The issue rule reserves a slot per outstanding request.
   always @(posedge clk_i) begin
      if (!rst_i) assert (!(fifo_push && fifo_full));
   end

   assign instr_req_o          = req;
   assign instr_addr_o         = fetch_pc_q;
   assign fetch_instr_o        = instr_q;
   assign fetch_new_instr_o    = new_q;
   assign fetch_pb_instr_tag_o = tag_q;
   assign fetch_penality_o     = pen_q;
   assign fetch_next_pc_o      = next_pc_q;

endmodule
